vec_mem_responder: RTL and testbench



---
 rtl/vec_mem_responder.sv | 142 ++++++++++++++
 tb/tb_vec_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_responder.sv
// Byte-wide memory responder for the core's data bus: single-byte and 4-byte
// burst reads/writes, one byte per cycle after a programmable wait-state delay.
module vec_mem_responder #(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH       = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_burst,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [1:0]  beat_q, beat_d;
  logic [7:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic        burst_q, burst_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  // Storage is deliberately outside the reset domain so contents survive reset.
  logic [7:0]  mem [DEPTH];

  logic [7:0]  acc_addr;
  logic [7:0]  wr_byte;
  logic [7:0]  rd_byte;
  logic [7:0]  wlane [4];
  logic        mem_we;
  logic [1:0]  last_beat;

  // Byte address wraps mod 256 naturally through the 8-bit add.
  assign acc_addr  = addr_q + {6'd0, beat_q};
  assign last_beat = burst_q ? 2'd3 : 2'd0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
      assign wlane[gi] = wdata_q[8*gi +: 8];
    end
  endgenerate

  assign wr_byte = wlane[beat_q];
  assign rd_byte = mem[acc_addr];
  assign mem_we  = (state_q == ST_ACCESS) && write_q;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[acc_addr] <= wr_byte;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    write_d    = write_q;
    burst_d    = burst_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          write_d    = req_write;
          burst_d    = req_burst;
          wdata_d    = req_wdata;
          rsp_data_d = 32'd0;
          beat_d     = 2'd0;
          wait_d     = WAIT_INIT;
          state_d    = (WAIT_INIT != 3'd0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        wait_d = wait_q - 3'd1;
        if (wait_q <= 3'd1) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!write_q) begin
          rsp_data_d[{beat_q, 3'b000} +: 8] = rd_byte;
        end
        if (beat_q == last_beat) begin
          state_d = ST_RESP;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_q     <= 3'd0;
      beat_q     <= 2'd0;
      addr_q     <= 8'd0;
      write_q    <= 1'b0;
      burst_q    <= 1'b0;
      wdata_q    <= 32'd0;
      rsp_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      burst_q    <= burst_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_vec_mem_responder.sv
// Scoreboard bench for vec_mem_responder: one WAIT_CYCLES=1 and one
// WAIT_CYCLES=0 instance driven by directed requests.
module tb_vec_mem_responder;

  logic        clock;
  logic        reset;
  logic        req_valid0, req_valid1;
  logic        req_write, req_burst;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready0, req_ready1;
  logic        rsp_valid0, rsp_valid1;
  logic [31:0] rsp_data0, rsp_data1;
  logic        busy0, busy1;

  typedef struct {
    logic [31:0] data;
    int          due;
    int          blen;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   brun0 = 0;

  vec_mem_responder #(.WAIT_CYCLES(1), .DEPTH(256)) dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .req_burst(req_burst), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .busy(busy0)
  );

  vec_mem_responder #(.WAIT_CYCLES(0), .DEPTH(256)) dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_burst(req_burst), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy(busy1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
  endtask

  // Monitor for the W=1 instance: data, latency, busy window and ready at completion.
  always @(negedge clock) begin
    exp_t e;
    if (busy0) brun0 = brun0 + 1;
    else brun0 = 0;
    if (rsp_valid0) begin
      if (q0.size() == 0) begin
        fail_now("w1_unexpected_rsp");
      end else begin
        e = q0.pop_front();
        chk("w1_rsp_data", rsp_data0, e.data);
        chk("w1_rsp_cycle", cyc, e.due);
        chk("w1_busy_len", brun0, e.blen);
        chk("w1_ready_low_in_resp", {31'd0, req_ready0}, 32'd0);
        $display("W1 rsp data=0x%08h cycle=%0d busy_len=%0d", rsp_data0, cyc, brun0);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (rsp_valid1) begin
      if (q1.size() == 0) begin
        fail_now("w0_unexpected_rsp");
      end else begin
        e = q1.pop_front();
        chk("w0_rsp_data", rsp_data1, e.data);
        chk("w0_rsp_cycle", cyc, e.due);
        $display("W0 rsp data=0x%08h cycle=%0d", rsp_data1, cyc);
      end
    end
  end

  // Issues one request; returns on the falling edge after the acceptance edge.
  task automatic issue(input bit inst, input bit wr, input bit bu, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_data, input int lat,
                       input int blen, input bit push, input bit hold, output int acc);
    int   n;
    exp_t e;
    @(negedge clock);
    req_write = wr;
    req_burst = bu;
    req_addr  = a;
    req_wdata = wd;
    if (inst) req_valid1 = 1'b1;
    else req_valid0 = 1'b1;
    n = 0;
    while (!(inst ? req_ready1 : req_ready0) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      fail_now("accept_timeout");
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (push) begin
      e.data = exp_data;
      e.due  = acc + lat;
      e.blen = blen;
      if (inst) q1.push_back(e);
      else q0.push_back(e);
    end
    $display("REQ inst=W%0d wr=%0d burst=%0d addr=0x%02h wdata=0x%08h accept_cycle=%0d",
             inst ? 0 : 1, wr, bu, a, wd, acc);
    @(negedge clock);
    if (!hold) begin
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) fail_now("drain_timeout");
  endtask

  initial begin
    int acc, acc1, acc2;
    reset = 1'b1;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    req_write = 1'b0;
    req_burst = 1'b0;
    req_addr = 8'd0;
    req_wdata = 32'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_req_ready", {31'd0, req_ready0}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid0}, 32'd0);
    chk("reset_rsp_data", rsp_data0, 32'd0);
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_w0_req_ready", {31'd0, req_ready1}, 32'd1);

    // Single write/read, W=1: latency 2, busy for 3 cycles.
    issue(0, 1, 0, 8'h10, 32'hFFFFFFA5, 32'h0, 2, 3, 1, 0, acc);
    issue(0, 0, 0, 8'h10, 32'h0, 32'h000000A5, 2, 3, 1, 0, acc);
    drain();

    // Burst write/read, then a single read from the middle of the burst.
    issue(0, 1, 1, 8'h20, 32'h44332211, 32'h0, 5, 6, 1, 0, acc);
    issue(0, 0, 1, 8'h20, 32'h0, 32'h44332211, 5, 6, 1, 0, acc);
    issue(0, 0, 0, 8'h22, 32'h0, 32'h00000033, 2, 3, 1, 0, acc);
    drain();

    // Burst crossing 0xFF -> 0x00.
    issue(0, 1, 1, 8'hFE, 32'hDDCCBBAA, 32'h0, 5, 6, 1, 0, acc);
    issue(0, 0, 0, 8'hFE, 32'h0, 32'h000000AA, 2, 3, 1, 0, acc);
    issue(0, 0, 0, 8'hFF, 32'h0, 32'h000000BB, 2, 3, 1, 0, acc);
    issue(0, 0, 0, 8'h00, 32'h0, 32'h000000CC, 2, 3, 1, 0, acc);
    issue(0, 0, 0, 8'h01, 32'h0, 32'h000000DD, 2, 3, 1, 0, acc);
    issue(0, 0, 1, 8'hFE, 32'h0, 32'hDDCCBBAA, 5, 6, 1, 0, acc);
    drain();

    // Back-to-back with req_valid held; inputs change mid-request to the second request.
    issue(0, 1, 0, 8'h30, 32'h0000005A, 32'h0, 2, 3, 1, 1, acc1);
    issue(0, 0, 0, 8'h30, 32'hFFFFFFFF, 32'h0000005A, 2, 3, 1, 0, acc2);
    chk("b2b_second_accept_cycle", acc2, acc1 + 4);
    drain();

    // Reset after two beats of a burst write.
    issue(0, 1, 1, 8'h40, 32'h00000000, 32'h0, 5, 6, 1, 0, acc);
    drain();
    issue(0, 1, 1, 8'h40, 32'h87654321, 32'h0, 5, 6, 0, 0, acc);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midreset_req_ready", {31'd0, req_ready0}, 32'd1);
    chk("midreset_rsp_valid", {31'd0, rsp_valid0}, 32'd0);
    chk("midreset_rsp_data", rsp_data0, 32'd0);
    chk("midreset_busy", {31'd0, busy0}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    issue(0, 0, 0, 8'h40, 32'h0, 32'h00000021, 2, 3, 1, 0, acc);
    issue(0, 0, 0, 8'h41, 32'h0, 32'h00000043, 2, 3, 1, 0, acc);
    issue(0, 0, 0, 8'h42, 32'h0, 32'h00000000, 2, 3, 1, 0, acc);
    issue(0, 0, 0, 8'h43, 32'h0, 32'h00000000, 2, 3, 1, 0, acc);
    drain();

    // W=0 instance: burst latency 4, single latency 1.
    issue(1, 1, 1, 8'h50, 32'hCAFEF00D, 32'h0, 4, 0, 1, 0, acc);
    issue(1, 0, 1, 8'h50, 32'h0, 32'hCAFEF00D, 4, 0, 1, 0, acc);
    issue(1, 0, 0, 8'h51, 32'h0, 32'h000000F0, 1, 0, 1, 0, acc);
    issue(1, 0, 0, 8'h53, 32'h0, 32'h000000CA, 1, 0, 1, 0, acc);
    drain();

    repeat (3) @(negedge clock);
    chk("w1_queue_empty", q0.size(), 32'd0);
    chk("w0_queue_empty", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
